// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with per-register busy scoreboard
// Two combinational read ports, one write/writeback port, one issue port.
module regfile_sb #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 8,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    S1,
    input  logic [AW-1:0]    S2,
    output logic [WIDTH-1:0] V1,
    output logic [WIDTH-1:0] V2,
    input  logic             RW,
    input  logic [AW-1:0]    D,
    input  logic [WIDTH-1:0] WV,
    input  logic             IS,
    input  logic [AW-1:0]    ID,
    output logic             B1,
    output logic             B2,
    output logic [AW:0]      BCNT
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             wr_en;
    logic             iss_en;
    logic             zero1;
    logic             zero2;
    logic [AW:0]      cnt;

    assign wr_en  = RW && !(ZERO_R0 && (D == '0));
    assign iss_en = IS && !(ZERO_R0 && (ID == '0));
    assign zero1  = ZERO_R0 && (S1 == '0);
    assign zero2  = ZERO_R0 && (S2 == '0);

    // Issue is applied after writeback so a coincident re-issue leaves the register busy.
    always_comb begin
        busy_d = busy_q;
        if (RW) begin
            busy_d[D] = 1'b0;
        end
        if (iss_en) begin
            busy_d[ID] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            if (wr_en) begin
                mem_q[D] <= WV;
            end
        end
    end

    always_comb begin
        V1 = mem_q[S1];
        V2 = mem_q[S2];
        B1 = busy_q[S1];
        B2 = busy_q[S2];
        if (BYPASS && RW && (D == S1)) begin
            V1 = WV;
            if (!(IS && (ID == S1))) begin
                B1 = 1'b0;
            end
        end
        if (BYPASS && RW && (D == S2)) begin
            V2 = WV;
            if (!(IS && (ID == S2))) begin
                B2 = 1'b0;
            end
        end
        if (zero1) begin
            V1 = '0;
            B1 = 1'b0;
        end
        if (zero2) begin
            V2 = '0;
            B2 = 1'b0;
        end
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + {{AW{1'b0}}, busy_q[i]};
        end
    end

    assign BCNT = cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed bench for regfile_sb
// Instance a uses default parameters; instance b has ZERO_R0=0, BYPASS=0.
module tb_regfile_sb;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_rw, a_is, a_b1, a_b2;
    logic [2:0]  a_s1, a_s2, a_d, a_id;
    logic [15:0] a_wv, a_v1, a_v2;
    logic [3:0]  a_bcnt;

    logic        b_rst, b_rw, b_is, b_b1, b_b2;
    logic [2:0]  b_s1, b_s2, b_d, b_id;
    logic [15:0] b_wv, b_v1, b_v2;
    logic [3:0]  b_bcnt;

    int total = 0;
    int bad   = 0;

    regfile_sb u_a (
        .clk(clk), .rst(a_rst), .S1(a_s1), .S2(a_s2), .V1(a_v1), .V2(a_v2),
        .RW(a_rw), .D(a_d), .WV(a_wv), .IS(a_is), .ID(a_id),
        .B1(a_b1), .B2(a_b2), .BCNT(a_bcnt)
    );

    regfile_sb #(.WIDTH(16), .DEPTH(8), .ZERO_R0(1'b0), .BYPASS(1'b0)) u_b (
        .clk(clk), .rst(b_rst), .S1(b_s1), .S2(b_s2), .V1(b_v1), .V2(b_v2),
        .RW(b_rw), .D(b_d), .WV(b_wv), .IS(b_is), .ID(b_id),
        .B1(b_b1), .B2(b_b2), .BCNT(b_bcnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Advance past the next rising edge; inputs changed afterwards settle before checks.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_rst = 1'b1; a_rw = 1'b0; a_is = 1'b0; a_s1 = 3'd3; a_s2 = 3'd5;
        a_d = 3'd0; a_id = 3'd0; a_wv = 16'h0;
        b_rst = 1'b1; b_rw = 1'b0; b_is = 1'b0; b_s1 = 3'd0; b_s2 = 3'd0;
        b_d = 3'd0; b_id = 3'd0; b_wv = 16'h0;
        tick();
        tick();
        a_rst = 1'b0;
        b_rst = 1'b0;
        #1;
        chk("rst_v1", a_v1, 16'h0);
        chk("rst_v2", a_v2, 16'h0);
        chk("rst_b1", a_b1, 1'b0);
        chk("rst_b2", a_b2, 1'b0);
        chk("rst_bcnt", a_bcnt, 4'd0);

        a_rw = 1'b1; a_d = 3'd3; a_wv = 16'hABCD; a_s1 = 3'd3;
        #1;
        chk("bypass_v1", a_v1, 16'hABCD);
        tick();
        a_rw = 1'b0; a_wv = 16'h0;
        #1;
        chk("write_v1", a_v1, 16'hABCD);

        a_rw = 1'b1; a_d = 3'd0; a_wv = 16'hFFFF; a_is = 1'b1; a_id = 3'd0; a_s1 = 3'd0;
        #1;
        chk("r0_bypass_v1", a_v1, 16'h0);
        chk("r0_bypass_b1", a_b1, 1'b0);
        tick();
        a_rw = 1'b0; a_is = 1'b0;
        #1;
        chk("r0_v1", a_v1, 16'h0);
        chk("r0_b1", a_b1, 1'b0);
        chk("r0_bcnt", a_bcnt, 4'd0);

        a_is = 1'b1; a_id = 3'd2;
        tick();
        a_id = 3'd5;
        #1;
        chk("issue2_bcnt", a_bcnt, 4'd1);
        tick();
        a_is = 1'b0; a_s2 = 3'd5; a_s1 = 3'd2;
        #1;
        chk("issue5_bcnt", a_bcnt, 4'd2);
        chk("issue5_b2", a_b2, 1'b1);
        chk("issue2_b1", a_b1, 1'b1);
        a_rw = 1'b1; a_d = 3'd2; a_wv = 16'h0777;
        #1;
        chk("wb_bypass_b1", a_b1, 1'b0);
        chk("wb_bypass_v1", a_v1, 16'h0777);
        chk("wb_port2_b2", a_b2, 1'b1);
        tick();
        a_rw = 1'b0;
        #1;
        chk("wb_bcnt", a_bcnt, 4'd1);
        chk("wb_b1", a_b1, 1'b0);
        chk("wb_v1", a_v1, 16'h0777);

        a_is = 1'b1; a_id = 3'd4; a_rw = 1'b1; a_d = 3'd4; a_wv = 16'h0042; a_s1 = 3'd4;
        #1;
        chk("coinc_pre_b1", a_b1, 1'b0);
        tick();
        a_is = 1'b0; a_rw = 1'b0; a_wv = 16'h0;
        #1;
        chk("coinc_v1", a_v1, 16'h0042);
        chk("coinc_b1", a_b1, 1'b1);
        chk("coinc_bcnt", a_bcnt, 4'd2);
        a_s2 = 3'd4;
        #1;
        chk("same_idx_v2", a_v2, 16'h0042);
        chk("same_idx_b2", a_b2, 1'b1);

        a_is = 1'b1; a_id = 3'd5;
        tick();
        a_is = 1'b0;
        #1;
        chk("reissue_bcnt", a_bcnt, 4'd2);

        a_rst = 1'b1; a_rw = 1'b1; a_d = 3'd7; a_wv = 16'h1111; a_is = 1'b1; a_id = 3'd6;
        tick();
        a_rst = 1'b0; a_rw = 1'b0; a_is = 1'b0; a_s1 = 3'd7; a_s2 = 3'd3;
        #1;
        chk("midrst_v1", a_v1, 16'h0);
        chk("midrst_v2", a_v2, 16'h0);
        chk("midrst_bcnt", a_bcnt, 4'd0);

        for (int i = 0; i < 8; i++) begin
            b_is = 1'b1; b_id = 3'(i);
            tick();
        end
        b_is = 1'b0;
        #1;
        chk("all_busy_bcnt", b_bcnt, 4'd8);
        b_s1 = 3'd0; b_s2 = 3'd7;
        #1;
        chk("all_busy_b1_r0", b_b1, 1'b1);
        chk("all_busy_b2_r7", b_b2, 1'b1);

        b_rst = 1'b1; b_is = 1'b1; b_id = 3'd1;
        tick();
        b_rst = 1'b0; b_is = 1'b0;
        #1;
        chk("rst_dom_bcnt", b_bcnt, 4'd0);
        for (int i = 0; i < 8; i++) begin
            b_s1 = 3'(i);
            #1;
            chk("rst_dom_b1", b_b1, 1'b0);
            chk("rst_dom_v1", b_v1, 16'h0);
        end

        b_rw = 1'b1; b_d = 3'd6; b_wv = 16'h1111;
        tick();
        b_wv = 16'h1234; b_s1 = 3'd6;
        #1;
        chk("nobyp_old_v1", b_v1, 16'h1111);
        tick();
        b_rw = 1'b0;
        #1;
        chk("nobyp_new_v1", b_v1, 16'h1234);

        b_rw = 1'b1; b_d = 3'd0; b_wv = 16'hFFFF; b_s2 = 3'd0;
        #1;
        chk("nobyp_r0_old_v2", b_v2, 16'h0);
        tick();
        b_rw = 1'b0;
        #1;
        chk("r0_writable_v2", b_v2, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter WIDTH, default 16, data width of each register.
REQ-002 Parameter DEPTH, default 8, number of registers; SHALL be a power of two, at least 2.
REQ-003 Parameter ZERO_R0, default 1; when 1, register 0 reads as zero and is never written or marked busy.
REQ-004 Parameter BYPASS, default 1; when 1, same-cycle write data and write-clear are forwarded to the read outputs.
REQ-005 Derived AW = log2(DEPTH), index width.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 rst  in  1  reset, synchronous and active-high.
REQ-008 S1  in  AW  read port 1 index.
REQ-009 S2  in  AW  read port 2 index.
REQ-010 V1  out  WIDTH  read port 1 data.
REQ-011 V2  out  WIDTH  read port 2 data.
REQ-012 RW  in  1  write enable; writeback also clears busy[D].
REQ-013 D  in  AW  write index.
REQ-014 WV  in  WIDTH  write data.
REQ-015 IS  in  1  issue strobe; marks busy[ID].
REQ-016 ID  in  AW  issue destination index.
REQ-017 B1  out  1  busy flag for S1.
REQ-018 B2  out  1  busy flag for S2.
REQ-019 BCNT  out  AW+1  count of busy registers.

Function
REQ-020 Storage: DEPTH x WIDTH data registers and a DEPTH-bit busy vector.
REQ-021 Write: when RW=1 and rst=0, Register[D] <= WV at the clock edge; with ZERO_R0=1 and D=0, no write occurs.
REQ-022 Read: V1/V2 are combinational from Register[S1]/Register[S2], with zero latency.
REQ-023 With ZERO_R0=1, index 0 on either read port SHALL yield 0 and a busy flag of 0, regardless of other inputs.
REQ-024 Bypass (BYPASS=1): if RW=1 and D=Sx (and the index is not the forced-zero register), Vx=WV in the same cycle.
REQ-025 With BYPASS=0, Vx SHALL show the pre-edge stored value.
REQ-026 Issue: IS=1 sets busy[ID] at the edge; ignored for ID=0 when ZERO_R0=1.
REQ-027 Writeback: RW=1 clears busy[D] at the edge.
REQ-028 Simultaneous IS and RW with ID=D: busy[ID] ends set (new issue wins); data is still written.
REQ-029 Simultaneous IS and RW to different indices: both take effect.
REQ-030 Re-issue to an already busy register: it stays busy, and no count change occurs.
REQ-031 Bx = busy[Sx] registered value.
REQ-032 When BYPASS=1, Bx=0 if RW=1, D=Sx, and not (IS=1 and ID=Sx).
REQ-033 BCNT = population count of the registered busy vector, updated one cycle after IS/RW; range 0..DEPTH with no wrap.
REQ-034 Read ports are independent; S1=S2 returns identical data and flags.

Reset
REQ-035 rst=1 at an edge clears all data registers to 0 and all busy bits to 0.
REQ-036 rst dominates RW and IS in the same cycle.
REQ-037 After reset: V1=V2=0, B1=B2=0, BCNT=0.
REQ-038 Reset mid-operation discards pending busy state; no writes are lost except the one coincident with rst.

Verification
REQ-039 Reset, then RW=1, D=3, WV=16'hABCD; next cycle S1=3 -> V1=16'hABCD. Same cycle with BYPASS=1 -> V1=16'hABCD before the edge.
REQ-040 ZERO_R0=1: RW=1, D=0, WV=16'hFFFF; IS=1, ID=0 -> V1 at S1=0 is 0, B1=0, BCNT=0.
REQ-041 IS on ID=2, then ID=5 on consecutive cycles -> BCNT=1, then 2; S2=5 -> B2=1; RW on D=2 -> BCNT=1.
REQ-042 IS=1, ID=4 and RW=1, D=4, WV=16'h0042 in the same cycle -> Register[4]=16'h0042, busy[4]=1, and B1 at S1=4 is 1 after the edge.
REQ-043 Mark all 8 registers busy with ZERO_R0=0 -> BCNT=8. Assert rst together with IS=1, ID=1 -> BCNT=0, all busy flags 0, all data 0.
REQ-044 BYPASS=0: RW=1, D=6, WV=16'h1234, S1=6 -> V1 shows the old value in that cycle and 16'h1234 the next cycle.
